// File: rtl/bira_pkg.sv
// Shared types and widths for the BIRA fault-collection CAM: entry layout,
// FSM state encoding and the "empty bank" marker.
package bira_pkg;
    localparam int ADDR_W = 10;
    localparam int BNK_W  = 2;

    localparam logic [BNK_W-1:0] BNK_EMPTY = '0;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        COMMIT
    } cam_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        logic [BNK_W-1:0]  bnk;
    } flt_entry_t;
endpackage

// File: rtl/flt_entry_match.sv
// Per-slot comparator: does the latched fault share a row/column with this
// entry in the same bank, and is it an exact copy of it.
module flt_entry_match
    import bira_pkg::*;
(
    input  flt_entry_t flt_i,
    input  flt_entry_t ent_i,
    output logic       rc_hit,
    output logic       exact_hit
);
    logic bank_ok;

    // An empty slot carries bank 0 and therefore never matches anything.
    assign bank_ok   = (ent_i.bnk != BNK_EMPTY) && (ent_i.bnk == flt_i.bnk);
    assign rc_hit    = bank_ok && ((ent_i.row == flt_i.row) || (ent_i.col == flt_i.col));
    assign exact_hit = bank_ok && (ent_i.row == flt_i.row) && (ent_i.col == flt_i.col);
endmodule

// File: rtl/pivot_fault_cam.sv
// Pivot / non-pivot fault collector for BIRA. Define BIRA_DUP_FILTER_EN to drop
// exact duplicates of stored entries instead of consuming a non-pivot slot.
module pivot_fault_cam #(
    parameter int PIVOT_N = 8,
    parameter int NPIV_N  = 8,
    parameter int ADDR_W  = bira_pkg::ADDR_W,
    parameter int BNK_W   = bira_pkg::BNK_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flt_valid,
    output logic                                flt_ready,
    input  logic [ADDR_W-1:0]                   flt_row,
    input  logic [ADDR_W-1:0]                   flt_col,
    input  logic [BNK_W-1:0]                    flt_bnk,
    output logic [PIVOT_N*ADDR_W-1:0]           pvt_row,
    output logic [PIVOT_N*ADDR_W-1:0]           pvt_col,
    output logic [PIVOT_N*BNK_W-1:0]            pvt_bnk,
    output logic [NPIV_N*ADDR_W-1:0]            npv_row,
    output logic [NPIV_N*ADDR_W-1:0]            npv_col,
    output logic [NPIV_N*BNK_W-1:0]             npv_bnk,
    output logic [NPIV_N*$clog2(PIVOT_N)-1:0]   npv_pid,
    output logic [$clog2(PIVOT_N+1)-1:0]        pvt_cnt,
    output logic [$clog2(NPIV_N+1)-1:0]         npv_cnt,
    output logic                                overflow
);
    import bira_pkg::*;

    localparam int PID_W = $clog2(PIVOT_N);
    localparam int PC_W  = $clog2(PIVOT_N + 1);
    localparam int NC_W  = $clog2(NPIV_N + 1);
    localparam logic [PC_W-1:0] PVT_FULL = PC_W'(PIVOT_N);
    localparam logic [NC_W-1:0] NPV_FULL = NC_W'(NPIV_N);

    cam_state_t         state_q;
    flt_entry_t         flt_q;
    flt_entry_t         pvt_q [PIVOT_N];
    flt_entry_t         npv_q [NPIV_N];
    logic [PID_W-1:0]   pid_q [NPIV_N];
    logic [PC_W-1:0]    pvt_cnt_q;
    logic [NC_W-1:0]    npv_cnt_q;
    logic               overflow_q;
    logic               hit_q, dup_q;
    logic [PID_W-1:0]   hit_idx_q;

    logic               hit_d, dup_d, dup_any;
    logic [PID_W-1:0]   hit_idx_d;
    logic [PIVOT_N-1:0] pvt_rc, pvt_ex;
    logic [NPIV_N-1:0]  npv_rc_unused, npv_ex;

    genvar gi;
    generate
        for (gi = 0; gi < PIVOT_N; gi++) begin : g_pvt
            flt_entry_match u_match (
                .flt_i     (flt_q),
                .ent_i     (pvt_q[gi]),
                .rc_hit    (pvt_rc[gi]),
                .exact_hit (pvt_ex[gi])
            );
            assign pvt_row[gi*ADDR_W +: ADDR_W] = pvt_q[gi].row;
            assign pvt_col[gi*ADDR_W +: ADDR_W] = pvt_q[gi].col;
            assign pvt_bnk[gi*BNK_W +: BNK_W]   = pvt_q[gi].bnk;
        end
        for (gi = 0; gi < NPIV_N; gi++) begin : g_npv
            flt_entry_match u_match (
                .flt_i     (flt_q),
                .ent_i     (npv_q[gi]),
                .rc_hit    (npv_rc_unused[gi]),
                .exact_hit (npv_ex[gi])
            );
            assign npv_row[gi*ADDR_W +: ADDR_W] = npv_q[gi].row;
            assign npv_col[gi*ADDR_W +: ADDR_W] = npv_q[gi].col;
            assign npv_bnk[gi*BNK_W +: BNK_W]   = npv_q[gi].bnk;
            assign npv_pid[gi*PID_W +: PID_W]   = pid_q[gi];
        end
    endgenerate

    assign dup_any = (|pvt_ex) | (|npv_ex);

`ifdef BIRA_DUP_FILTER_EN
    assign dup_d = dup_any;
`else
    logic dup_unused;
    assign dup_unused = dup_any;
    assign dup_d      = 1'b0;
`endif

    // Descending scan so the lowest hitting slot wins as parent.
    always_comb begin
        hit_d     = |pvt_rc;
        hit_idx_d = '0;
        for (int i = PIVOT_N - 1; i >= 0; i--) begin
            if (pvt_rc[i]) hit_idx_d = PID_W'(i);
        end
    end

    assign flt_ready = (state_q == IDLE) && !rst;
    assign pvt_cnt   = pvt_cnt_q;
    assign npv_cnt   = npv_cnt_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            flt_q      <= '0;
            pvt_cnt_q  <= '0;
            npv_cnt_q  <= '0;
            overflow_q <= 1'b0;
            hit_q      <= 1'b0;
            dup_q      <= 1'b0;
            hit_idx_q  <= '0;
            for (int i = 0; i < PIVOT_N; i++) pvt_q[i] <= '0;
            for (int i = 0; i < NPIV_N; i++) begin
                npv_q[i] <= '0;
                pid_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (flt_valid) begin
                        flt_q   <= '{row: flt_row, col: flt_col, bnk: flt_bnk};
                        state_q <= SEARCH;
                    end
                end
                SEARCH: begin
                    hit_q     <= hit_d;
                    hit_idx_q <= hit_idx_d;
                    dup_q     <= dup_d;
                    state_q   <= COMMIT;
                end
                COMMIT: begin
                    state_q <= IDLE;
                    if (flt_q.bnk == BNK_EMPTY || overflow_q || dup_q) begin
                        // discarded
                    end else if (hit_q) begin
                        if (npv_cnt_q < NPV_FULL) begin
                            for (int i = 0; i < NPIV_N; i++) begin
                                if (npv_cnt_q == NC_W'(i)) begin
                                    npv_q[i] <= flt_q;
                                    pid_q[i] <= hit_idx_q;
                                end
                            end
                            npv_cnt_q <= npv_cnt_q + NC_W'(1);
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end else begin
                        if (pvt_cnt_q < PVT_FULL) begin
                            for (int i = 0; i < PIVOT_N; i++) begin
                                if (pvt_cnt_q == PC_W'(i)) pvt_q[i] <= flt_q;
                            end
                            pvt_cnt_q <= pvt_cnt_q + PC_W'(1);
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pivot_fault_cam.sv
// Bench for pivot_fault_cam: constant-table vectors, hand sequences for the
// boundaries, and random faults checked against a queue-based table model.
module tb_pivot_fault_cam;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flt_valid = 1'b0;
    logic        flt_ready;
    logic [9:0]  flt_row = '0, flt_col = '0;
    logic [1:0]  flt_bnk = '0;
    logic [79:0] pvt_row, pvt_col, npv_row, npv_col;
    logic [15:0] pvt_bnk, npv_bnk;
    logic [23:0] npv_pid;
    logic [3:0]  pvt_cnt, npv_cnt;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    pivot_fault_cam dut (
        .clk(clk), .rst(rst), .flt_valid(flt_valid), .flt_ready(flt_ready),
        .flt_row(flt_row), .flt_col(flt_col), .flt_bnk(flt_bnk),
        .pvt_row(pvt_row), .pvt_col(pvt_col), .pvt_bnk(pvt_bnk),
        .npv_row(npv_row), .npv_col(npv_col), .npv_bnk(npv_bnk),
        .npv_pid(npv_pid), .pvt_cnt(pvt_cnt), .npv_cnt(npv_cnt),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] row;
        logic [9:0] col;
        logic [1:0] bnk;
        int         pid;
    } ment_t;

    ment_t m_pvt[$];
    ment_t m_npv[$];
    bit    m_ovf;

    function automatic void model_clear();
        m_pvt.delete();
        m_npv.delete();
        m_ovf = 0;
    endfunction

    // Classification rules applied directly to the stored fault lists.
    function automatic void model_apply(logic [9:0] r, logic [9:0] c, logic [1:0] b);
        int parent = -1;
        if (b == 2'd0 || m_ovf) return;
`ifdef BIRA_DUP_FILTER_EN
        foreach (m_pvt[i]) if (m_pvt[i].row == r && m_pvt[i].col == c && m_pvt[i].bnk == b) return;
        foreach (m_npv[i]) if (m_npv[i].row == r && m_npv[i].col == c && m_npv[i].bnk == b) return;
`endif
        foreach (m_pvt[i])
            if (parent < 0 && m_pvt[i].bnk == b && (m_pvt[i].row == r || m_pvt[i].col == c))
                parent = i;
        if (parent >= 0) begin
            if (m_npv.size() < 8) m_npv.push_back('{r, c, b, parent});
            else m_ovf = 1;
        end else begin
            if (m_pvt.size() < 8) m_pvt.push_back('{r, c, b, 0});
            else m_ovf = 1;
        end
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_all(input string nm, input logic exp_rdy);
        logic [79:0] er = '0, ec = '0, nr = '0, nc = '0;
        logic [15:0] eb = '0, nb = '0;
        logic [23:0] ep = '0;
        foreach (m_pvt[i]) begin
            er[i*10 +: 10] = m_pvt[i].row;
            ec[i*10 +: 10] = m_pvt[i].col;
            eb[i*2 +: 2]   = m_pvt[i].bnk;
        end
        foreach (m_npv[i]) begin
            nr[i*10 +: 10] = m_npv[i].row;
            nc[i*10 +: 10] = m_npv[i].col;
            nb[i*2 +: 2]   = m_npv[i].bnk;
            ep[i*3 +: 3]   = 3'(m_npv[i].pid);
        end
        chk({nm, ".ready"},    128'(flt_ready), 128'(exp_rdy));
        chk({nm, ".pvt_cnt"},  128'(pvt_cnt),   128'(m_pvt.size()));
        chk({nm, ".npv_cnt"},  128'(npv_cnt),   128'(m_npv.size()));
        chk({nm, ".overflow"}, 128'(overflow),  128'(m_ovf));
        chk({nm, ".pvt_row"},  128'(pvt_row),   128'(er));
        chk({nm, ".pvt_col"},  128'(pvt_col),   128'(ec));
        chk({nm, ".pvt_bnk"},  128'(pvt_bnk),   128'(eb));
        chk({nm, ".npv_row"},  128'(npv_row),   128'(nr));
        chk({nm, ".npv_col"},  128'(npv_col),   128'(nc));
        chk({nm, ".npv_bnk"},  128'(npv_bnk),   128'(nb));
        chk({nm, ".npv_pid"},  128'(npv_pid),   128'(ep));
    endtask

    task automatic do_reset();
        flt_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst.ready_low", 128'(flt_ready), 128'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_clear();
        compare_all("after_reset", 1'b1);
    endtask

    // One accept; garbage is driven with valid=1 while busy to prove it is ignored.
    task automatic send(input logic [9:0] r, input logic [9:0] c, input logic [1:0] b);
        int g = 0;
        while (flt_ready !== 1'b1 && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("send.ready_wait", 128'(flt_ready), 128'(1));
        flt_valid = 1'b1;
        flt_row = r; flt_col = c; flt_bnk = b;
        @(posedge clk); #1;
        chk("send.busy_search", 128'(flt_ready), 128'(0));
        flt_row = 10'($urandom); flt_col = 10'($urandom); flt_bnk = 2'($urandom);
        @(posedge clk); #1;
        flt_valid = 1'b0;
        compare_all("pre_commit", 1'b0);
        model_apply(r, c, b);
        @(posedge clk); #1;
        compare_all("post_commit", 1'b1);
    endtask

    typedef struct {
        logic [9:0] row;
        logic [9:0] col;
        logic [1:0] bnk;
        int         exp_pvt;
        int         exp_npv;
    } tv_t;

    tv_t tv [8];

    initial begin
        tv[0] = '{10'd5,   10'd9,   2'd1, 1, 0};
        tv[1] = '{10'd5,   10'd300, 2'd1, 1, 1};
        tv[2] = '{10'd5,   10'd9,   2'd2, 2, 1};
        tv[3] = '{10'd7,   10'd7,   2'd0, 2, 1};
`ifdef BIRA_DUP_FILTER_EN
        tv[4] = '{10'd5,   10'd9,   2'd1, 2, 1};
        tv[5] = '{10'd6,   10'd9,   2'd1, 2, 2};
        tv[6] = '{10'd8,   10'd20,  2'd1, 3, 2};
        tv[7] = '{10'd8,   10'd9,   2'd1, 3, 3};
`else
        tv[4] = '{10'd5,   10'd9,   2'd1, 2, 2};
        tv[5] = '{10'd6,   10'd9,   2'd1, 2, 3};
        tv[6] = '{10'd8,   10'd20,  2'd1, 3, 3};
        tv[7] = '{10'd8,   10'd9,   2'd1, 3, 4};
`endif

        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(tv[i].row, tv[i].col, tv[i].bnk);
            chk($sformatf("tv%0d.pvt_cnt", i), 128'(pvt_cnt), 128'(tv[i].exp_pvt));
            chk($sformatf("tv%0d.npv_cnt", i), 128'(npv_cnt), 128'(tv[i].exp_npv));
            chk($sformatf("tv%0d.overflow", i), 128'(overflow), 128'(0));
        end
        chk("tv.npv0_col", 128'(npv_col[9:0]), 128'(300));
        chk("tv.npv0_pid", 128'(npv_pid[2:0]), 128'(0));

        // Reset arriving in the SEARCH cycle must abort the fault.
        flt_valid = 1'b1; flt_row = 10'd11; flt_col = 10'd12; flt_bnk = 2'd3;
        @(posedge clk); #1;
        flt_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst.ready_low", 128'(flt_ready), 128'(0));
        rst = 1'b0;
        model_clear();
        #1;
        compare_all("midrst.next", 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        compare_all("midrst.later", 1'b1);

        // Pivot table boundary and sticky overflow.
        do_reset();
        for (int i = 0; i < 8; i++) send(10'(100 + i), 10'(200 + i), 2'd3);
        chk("pfull.pvt_cnt", 128'(pvt_cnt), 128'(8));
        chk("pfull.overflow", 128'(overflow), 128'(0));
        send(10'd150, 10'd250, 2'd3);
        chk("povf.overflow", 128'(overflow), 128'(1));
        chk("povf.pvt_cnt", 128'(pvt_cnt), 128'(8));
        send(10'd100, 10'd999, 2'd3);
        chk("povf_hit.npv_cnt", 128'(npv_cnt), 128'(0));
        chk("povf_hit.overflow", 128'(overflow), 128'(1));

        // Non-pivot table boundary.
        do_reset();
        send(10'd1, 10'd1, 2'd1);
        for (int i = 0; i < 8; i++) send(10'd1, 10'(10 + i), 2'd1);
        chk("nfull.npv_cnt", 128'(npv_cnt), 128'(8));
        chk("nfull.overflow", 128'(overflow), 128'(0));
        send(10'd1, 10'd50, 2'd1);
        chk("novf.overflow", 128'(overflow), 128'(1));
        chk("novf.npv_cnt", 128'(npv_cnt), 128'(8));

        // Random faults on a small address space so hits and overflow are common.
        for (int rnd = 0; rnd < 3; rnd++) begin
            do_reset();
            for (int k = 0; k < 30; k++) begin
                send(10'($urandom_range(0, 5)), 10'($urandom_range(0, 5)),
                     2'($urandom_range(0, 3)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
